// File: rtl/aexm_dmem_port.sv
// Data-memory access stage: turns an execute-stage load/store into a big-endian dcache request.
// Define AEXM_DMEM_MISALIGN_TRAP_EN to trap misaligned or size-3 accesses instead of issuing them.
module aexm_dmem_port #(
  parameter int TMO_CYC = 255
) (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_stall,
  output logic        lsu_berr,
  output logic        lsu_misalign,
  output logic [3:0]  rDWBSEL,
  output logic [31:0] aexm_dcache_datai,
  output logic        dc_req,
  output logic        dc_we,
  output logic [29:0] dc_addr,
  output logic [3:0]  dc_sel,
  output logic [31:0] dc_wdata,
  input  logic        dc_ack,
  input  logic [31:0] dc_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  stateT       state;
  stateT       stateNext;
  logic [7:0]  tmoCnt;
  logic [3:0]  laneSel;
  logic        trapReq;

  // Big-endian lanes: byte 0 of a word lives in [31:24]; misaligned low bits are dropped.
  always_comb begin
    laneSel = 4'h0;
    case (lsu_size)
      2'd0: begin
        case (lsu_addr[1:0])
          2'd0:    laneSel = 4'h8;
          2'd1:    laneSel = 4'h4;
          2'd2:    laneSel = 4'h2;
          default: laneSel = 4'h1;
        endcase
      end
      2'd1:    laneSel = lsu_addr[1] ? 4'h3 : 4'hC;
      2'd2:    laneSel = 4'hF;
      default: laneSel = 4'h0;
    endcase
  end

`ifdef AEXM_DMEM_MISALIGN_TRAP_EN
  assign trapReq = (lsu_size == 2'd3) ||
                   ((lsu_size == 2'd2) && (lsu_addr[1:0] != 2'd0)) ||
                   ((lsu_size == 2'd1) && lsu_addr[0]);
`else
  assign trapReq = 1'b0;
`endif

  assign lsu_misalign = (state == IDLE) && lsu_req && trapReq;

  always_comb begin
    stateNext = state;
    lsu_stall = 1'b0;
    case (state)
      IDLE: begin
        lsu_stall = lsu_req;
        if (lsu_req) stateNext = trapReq ? DONE : BUSY;
      end
      BUSY: begin
        lsu_stall = 1'b1;
        if (dc_ack || (tmoCnt == TMO_LAST)) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Ack is checked before the timeout so a last-cycle ack still completes cleanly.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state             <= IDLE;
      tmoCnt            <= 8'd0;
      dc_req            <= 1'b0;
      dc_we             <= 1'b0;
      dc_addr           <= 30'd0;
      dc_sel            <= 4'h0;
      dc_wdata          <= 32'd0;
      lsu_berr          <= 1'b0;
      rDWBSEL           <= 4'h0;
      aexm_dcache_datai <= 32'd0;
    end else begin
      state    <= stateNext;
      lsu_berr <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_req && !trapReq) begin
            dc_req   <= 1'b1;
            dc_we    <= lsu_we;
            dc_addr  <= lsu_addr[31:2];
            dc_sel   <= laneSel;
            dc_wdata <= lsu_wdata;
            tmoCnt   <= 8'd0;
          end
        end
        BUSY: begin
          if (dc_ack) begin
            dc_req <= 1'b0;
            if (!dc_we) begin
              aexm_dcache_datai <= dc_rdata;
              rDWBSEL           <= dc_sel;
            end
          end else if (tmoCnt == TMO_LAST) begin
            dc_req            <= 1'b0;
            lsu_berr          <= 1'b1;
            aexm_dcache_datai <= 32'd0;
            rDWBSEL           <= 4'hF;
          end else begin
            tmoCnt <= tmoCnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aexm_dmem_port.sv
// Randomized self-checking bench for aexm_dmem_port against a transaction-level model.
// Expected lanes and results come from the access rules, one transaction at a time.
module tb_aexm_dmem_port;

  localparam int TMO = 12;

  logic        gclk = 1'b0;
  logic        grst_n;
  logic        lsu_req;
  logic        lsu_we;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_stall;
  logic        lsu_berr;
  logic        lsu_misalign;
  logic [3:0]  rDWBSEL;
  logic [31:0] aexm_dcache_datai;
  logic        dc_req;
  logic        dc_we;
  logic [29:0] dc_addr;
  logic [3:0]  dc_sel;
  logic [31:0] dc_wdata;
  logic        dc_ack;
  logic [31:0] dc_rdata;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [3:0]  expSel;
  logic [31:0] expData;

  aexm_dmem_port #(.TMO_CYC(TMO)) dut (
    .gclk(gclk), .grst_n(grst_n),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_stall(lsu_stall), .lsu_berr(lsu_berr), .lsu_misalign(lsu_misalign),
    .rDWBSEL(rDWBSEL), .aexm_dcache_datai(aexm_dcache_datai),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_sel(dc_sel),
    .dc_wdata(dc_wdata), .dc_ack(dc_ack), .dc_rdata(dc_rdata)
  );

  always #5 gclk = ~gclk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte n of a big-endian word sits in lane 3-n; a half covers two adjacent lanes.
  function automatic logic [3:0] refLane(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 4'(1 << (3 - a));
      2'd1:    return (a < 2'd2) ? 4'hC : 4'h3;
      2'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic bit refMisaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'd3) || (size == 2'd2 && a != 2'd0) || (size == 2'd1 && a[0]);
  endfunction

  // ackAt: BUSY cycle index on which dc_ack is raised; >= TMO means never.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input int ackAt, input logic [31:0] rdata);
    logic [3:0] lane;
    bit acked;
    lane  = refLane(size, addr[1:0]);
    acked = 1'b0;
    @(negedge gclk);
    checkOutput("idleReqLow", 32'(dc_req), 32'd0);
    checkOutput("idleBerrLow", 32'(lsu_berr), 32'd0);
    lsu_req   = 1'b1;
    lsu_we    = we;
    lsu_size  = size;
    lsu_addr  = addr;
    lsu_wdata = wdata;
    dc_ack    = 1'($urandom_range(0, 1));
    dc_rdata  = $urandom;
    #1;
    checkOutput("idleStall", 32'(lsu_stall), 32'd1);
`ifdef AEXM_DMEM_MISALIGN_TRAP_EN
    if (refMisaligned(size, addr[1:0])) begin
      checkOutput("trapPulse", 32'(lsu_misalign), 32'd1);
      @(negedge gclk);
      checkOutput("trapNoReq", 32'(dc_req), 32'd0);
      checkOutput("trapSel", 32'(rDWBSEL), 32'(expSel));
      checkOutput("trapData", aexm_dcache_datai, expData);
      checkOutput("trapPulseEnd", 32'(lsu_misalign), 32'd0);
      lsu_req = 1'($urandom_range(0, 1));
      #1;
      checkOutput("trapDoneStall", 32'(lsu_stall), 32'd0);
      return;
    end
`endif
    checkOutput("idleMisalign", 32'(lsu_misalign), 32'd0);
    for (int i = 0; i < TMO; i++) begin
      @(negedge gclk);
      checkOutput("busyReq", 32'(dc_req), 32'd1);
      checkOutput("busyStall", 32'(lsu_stall), 32'd1);
      checkOutput("busyAddr", 32'(dc_addr), addr >> 2);
      checkOutput("busySel", 32'(dc_sel), 32'(lane));
      checkOutput("busyWe", 32'(dc_we), 32'(we));
      checkOutput("busyWdata", dc_wdata, wdata);
      checkOutput("busyBerr", 32'(lsu_berr), 32'd0);
      dc_ack   = (i == ackAt);
      dc_rdata = (i == ackAt) ? rdata : $urandom;
      if (i == ackAt) begin
        acked = 1'b1;
        break;
      end
    end
    @(negedge gclk);
    dc_ack = 1'b0;
    if (acked) begin
      if (!we) begin
        expData = rdata;
        expSel  = lane;
      end
    end else begin
      expData = 32'd0;
      expSel  = 4'hF;
    end
    checkOutput("doneReq", 32'(dc_req), 32'd0);
    checkOutput("doneBerr", 32'(lsu_berr), acked ? 32'd0 : 32'd1);
    checkOutput("doneSel", 32'(rDWBSEL), 32'(expSel));
    checkOutput("doneData", aexm_dcache_datai, expData);
    lsu_req  = 1'($urandom_range(0, 1));
    lsu_addr = $urandom;
    #1;
    checkOutput("doneStall", 32'(lsu_stall), 32'd0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge gclk);
      lsu_req  = 1'b0;
      dc_ack   = 1'($urandom_range(0, 1));
      dc_rdata = $urandom;
      #1;
      checkOutput("gapStall", 32'(lsu_stall), 32'd0);
      checkOutput("gapReq", 32'(dc_req), 32'd0);
      checkOutput("gapSel", 32'(rDWBSEL), 32'(expSel));
      checkOutput("gapData", aexm_dcache_datai, expData);
    end
    @(negedge gclk);
    dc_ack = 1'b0;
  endtask

  task automatic resetMidBusy(input int busyCycles);
    @(negedge gclk);
    lsu_req  = 1'b1;
    lsu_we   = 1'b0;
    lsu_size = 2'd2;
    lsu_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    dc_ack   = 1'b0;
    repeat (busyCycles) @(negedge gclk);
    checkOutput("preRstReq", 32'(dc_req), 32'd1);
    grst_n  = 1'b0;
    lsu_req = 1'b0;
    #1;
    expSel  = 4'h0;
    expData = 32'd0;
    checkOutput("rstReq", 32'(dc_req), 32'd0);
    checkOutput("rstStall", 32'(lsu_stall), 32'd0);
    checkOutput("rstBerr", 32'(lsu_berr), 32'd0);
    checkOutput("rstSel", 32'(rDWBSEL), 32'h0);
    checkOutput("rstData", aexm_dcache_datai, 32'h0);
    checkOutput("rstDcSel", 32'(dc_sel), 32'h0);
    @(negedge gclk);
    grst_n = 1'b1;
  endtask

  initial begin
    int pick;
    logic [1:0] sz;
    logic [31:0] ad;
    grst_n    = 1'b0;
    lsu_req   = 1'b0;
    lsu_we    = 1'b0;
    lsu_size  = 2'd0;
    lsu_addr  = 32'd0;
    lsu_wdata = 32'd0;
    dc_ack    = 1'b0;
    dc_rdata  = 32'd0;
    expSel    = 4'h0;
    expData   = 32'd0;
    repeat (2) @(negedge gclk);
    checkOutput("resetReq", 32'(dc_req), 32'd0);
    checkOutput("resetStall", 32'(lsu_stall), 32'd0);
    checkOutput("resetBerr", 32'(lsu_berr), 32'd0);
    checkOutput("resetMisalign", 32'(lsu_misalign), 32'd0);
    checkOutput("resetSel", 32'(rDWBSEL), 32'h0);
    checkOutput("resetData", aexm_dcache_datai, 32'h0);
    checkOutput("resetWe", 32'(dc_we), 32'd0);
    grst_n = 1'b1;

    $display("[TB] directed scenarios");
    applyStimulus(1'b0, 2'd2, 32'h0000_0100, 32'h1234_5678, 3, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 2'd0, 32'h0000_0203, 32'h5A5A_5A5A, 0, 32'h0);
    applyStimulus(1'b0, 2'd2, 32'h0000_0400, 32'h0, TMO, 32'h0);
    applyStimulus(1'b0, 2'd2, 32'h0000_0404, 32'h0, TMO - 1, 32'hCAFE_F00D);
    applyStimulus(1'b0, 2'd0, 32'h0000_0010, 32'h0, 0, 32'h1111_2222);
    applyStimulus(1'b0, 2'd1, 32'h0000_0012, 32'h0, 0, 32'h3333_4444);
    resetMidBusy(3);
    applyStimulus(1'b0, 2'd2, 32'h0000_0020, 32'h0, 1, 32'h0BAD_CAFE);
    applyStimulus(1'b0, 2'd1, 32'h0000_0101, 32'h0, 2, 32'h7777_8888);
    applyStimulus(1'b0, 2'd3, 32'h0000_0200, 32'h0, 0, 32'h9999_AAAA);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 9);
      sz   = 2'($urandom_range(0, 3));
      ad   = $urandom;
      if (n % 7 == 3) idleCycles($urandom_range(1, 3));
      if (n % 17 == 9) resetMidBusy($urandom_range(1, TMO - 1));
      applyStimulus(1'($urandom_range(0, 1)), sz, ad, $urandom,
                    (pick == 0) ? TMO : (pick == 1) ? TMO - 1 : $urandom_range(0, 4),
                    $urandom);
    end
    idleCycles(2);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
